// File: rtl/mem_responder.sv
// Wait-state memory target for the ram strobe interface: answers each accepted
// read/write with a one-cycle ready pulse after a fixed, per-direction wait.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic [2:0] {IDLE, RWAIT, RDONE, WWAIT, WDONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0] lat_data, lat_data_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_req, wr_req, bad_req;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              ready_nxt, oe_nxt, busy_nxt, err_nxt, mem_we;
  logic [DATA_W-1:0] dout_nxt;

  assign rd_req  = ena & read & ~write;
  assign wr_req  = ena & write & ~read;
  assign bad_req = ena & read & write;

  // A zero-wait access goes straight from IDLE to DONE, so it must use the live bus.
  assign acc_addr = (state == IDLE) ? addr : lat_addr;
  assign acc_data = (state == IDLE) ? data_in : lat_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      ready    <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_addr <= lat_addr_nxt;
      lat_data <= lat_data_nxt;
      ready    <= ready_nxt;
      data_oe  <= oe_nxt;
      data_out <= dout_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_addr_nxt = lat_addr;
    lat_data_nxt = lat_data;
    case (state)
      IDLE: begin
        if (rd_req) begin
          lat_addr_nxt = addr;
          cnt_nxt      = RD_CNT;
          state_nxt    = (RD_WAIT == 0) ? RDONE : RWAIT;
        end else if (wr_req) begin
          lat_addr_nxt = addr;
          lat_data_nxt = data_in;
          cnt_nxt      = WR_CNT;
          state_nxt    = (WR_WAIT == 0) ? WDONE : WWAIT;
        end
      end
      RWAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RDONE;
      end
      WWAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = WDONE;
      end
      RDONE:   state_nxt = IDLE;
      WDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they land in registers.
  always_comb begin
    ready_nxt = (state_nxt == RDONE) || (state_nxt == WDONE);
    oe_nxt    = (state_nxt == RDONE);
    dout_nxt  = oe_nxt ? mem[acc_addr] : '0;
    busy_nxt  = (state_nxt != IDLE);
    err_nxt   = (state == IDLE) && bad_req;
    mem_we    = (state_nxt == WDONE);
  end

  // Commit on the edge entering WDONE; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[acc_addr] <= acc_data;
  end

endmodule
